// File: rtl/button_pkg.sv
// Shared types and constants for the button front end.
// Channel FSM states and bit positions of the mode-hub buttons.
package button_pkg;

    typedef enum logic [1:0] {
        LOCKED = 2'd0,
        IDLE   = 2'd1,
        HELD   = 2'd2,
        REPEAT = 2'd3
    } btn_state_t;

    localparam int BTN_MODE  = 0;
    localparam int BTN_MINUS = 1;
    localparam int BTN_PLUS  = 2;
    localparam int BTN_4     = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/button_pulse_gen_if.sv
// Button bank bus: raw pins and enable in, press pulses and levels out.
// Master drives the pins; slave is the pulse generator.
interface button_pulse_gen_if #(
    parameter int N_BUTTONS = 4
);
    logic                 enable_i;
    logic [N_BUTTONS-1:0] button_i;
    logic [N_BUTTONS-1:0] press_o;
    logic [N_BUTTONS-1:0] level_o;

    modport master (
        output enable_i, button_i,
        input  press_o, level_o
    );

    modport slave (
        input  enable_i, button_i,
        output press_o, level_o
    );
endinterface

// File: rtl/button_channel.sv
// One button channel: sync, debounce, power-up lockout, press FSM.
// Hold auto-repeat is built only with BUTTON_AUTOREPEAT_EN defined.
module button_channel
    import button_pkg::*;
#(
    parameter bit ACTIVE_LOW           = 1'b1,
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter bit REPEAT_EN            = 1'b0
) (
    input  logic clk_i,
    input  logic nReset_i,
    input  logic enable_i,
    input  logic pin_i,
    output logic press_o,
    output logic level_o
);

    localparam int CW = $clog2(max3(DEBOUNCE_CYCLES,
        REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 1);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          s1, s2;
    logic          deb, deb_q;
    logic [CW-1:0] dcnt;
    logic [1:0]    settle;
    logic          pulse_q;
    btn_state_t    state;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LAST = CW'(REPEAT_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] RP_LAST = CW'(REPEAT_PERIOD_CYCLES - 1);
    logic [CW-1:0] hcnt;
`else
    logic unused_cfg;
    assign unused_cfg = REPEAT_EN;
`endif

    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            deb    <= 1'b0;
            deb_q  <= 1'b0;
            dcnt   <= '0;
            settle <= 2'd0;
        end else begin
            s1    <= pin_i ^ ACTIVE_LOW;
            s2    <= s1;
            deb_q <= deb;
            if (settle != 2'd2)
                settle <= settle + 2'd1;
            if (s2 == deb) begin
                dcnt <= '0;
            end else if (dcnt == DEB_LAST) begin
                deb  <= s2;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end
        end
    end

    // Lockout ends only once the synced pin has been seen released
    always_ff @(posedge clk_i or negedge nReset_i) begin
        if (!nReset_i) begin
            state   <= LOCKED;
            pulse_q <= 1'b0;
            level_o <= 1'b0;
`ifdef BUTTON_AUTOREPEAT_EN
            hcnt    <= '0;
`endif
        end else begin
            pulse_q <= 1'b0;
            level_o <= deb_q;
            unique case (1'b1)
                state == LOCKED: begin
                    if (settle == 2'd2 && !deb_q && !deb && !s2)
                        state <= IDLE;
                end
                state == IDLE: begin
                    if (deb_q) begin
                        state   <= HELD;
                        pulse_q <= 1'b1;
`ifdef BUTTON_AUTOREPEAT_EN
                        hcnt    <= '0;
`endif
                    end
                end
                state == HELD: begin
                    if (!deb_q) begin
                        state <= IDLE;
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (REPEAT_EN) begin
                        if (hcnt == RD_LAST) begin
                            state   <= REPEAT;
                            hcnt    <= '0;
                            pulse_q <= 1'b1;
                        end else begin
                            hcnt <= hcnt + 1'b1;
                        end
                    end
`endif
                end
                default: begin
                    if (!deb_q) begin
                        state <= IDLE;
                    end
`ifdef BUTTON_AUTOREPEAT_EN
                    else if (hcnt == RP_LAST) begin
                        hcnt    <= '0;
                        pulse_q <= 1'b1;
                    end else begin
                        hcnt <= hcnt + 1'b1;
                    end
`endif
                end
            endcase
        end
    end

    assign press_o = pulse_q & enable_i;

endmodule

// File: rtl/button_pulse_gen.sv
// N-channel button front end producing one-clk press pulses.
// Define BUTTON_AUTOREPEAT_EN to enable hold auto-repeat on REPEAT_MASK channels.
module button_pulse_gen
    import button_pkg::*;
#(
    parameter int N_BUTTONS            = 4,
    parameter bit BUTTON_ACTIVE_LOW    = 1'b1,
    parameter int DEBOUNCE_CYCLES      = 500000,
    parameter int REPEAT_DELAY_CYCLES  = 25000000,
    parameter int REPEAT_PERIOD_CYCLES = 5000000,
    parameter logic [N_BUTTONS-1:0] REPEAT_MASK =
        N_BUTTONS'((1 << BTN_MINUS) | (1 << BTN_PLUS))
) (
    input logic clk_i,
    input logic nReset_i,
    button_pulse_gen_if.slave bus
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_channel #(
            .ACTIVE_LOW          (BUTTON_ACTIVE_LOW),
            .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
            .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
            .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES),
            .REPEAT_EN           (REPEAT_MASK[i])
        ) u_ch (
            .clk_i   (clk_i),
            .nReset_i(nReset_i),
            .enable_i(bus.enable_i),
            .pin_i   (bus.button_i[i]),
            .press_o (bus.press_o[i]),
            .level_o (bus.level_o[i])
        );
    end

endmodule

// File: tb/tb_button_pulse_gen.sv
// Directed bench for button_pulse_gen (DEBOUNCE=8, DELAY=40, PERIOD=10).
// Pulse edges are logged by a monitor and compared to hand-derived edges.
module tb_button_pulse_gen;

    typedef struct {
        int ch;
        int e;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   ecount = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    ev_t  evq[$];

    button_pulse_gen_if #(.N_BUTTONS(4)) bif ();

    button_pulse_gen #(
        .N_BUTTONS           (4),
        .BUTTON_ACTIVE_LOW   (1'b1),
        .DEBOUNCE_CYCLES     (8),
        .REPEAT_DELAY_CYCLES (40),
        .REPEAT_PERIOD_CYCLES(10),
        .REPEAT_MASK         (4'b0110)
    ) dut (
        .clk_i   (clk),
        .nReset_i(rst_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ecount++;
        #1;
        for (int i = 0; i < 4; i++)
            if (bif.press_o[i] === 1'b1)
                evq.push_back('{ch: i, e: ecount});
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic goto(input int e);
        while (ecount < e) tick(1);
    endtask

    function automatic int npulse(input int ch);
        int n = 0;
        foreach (evq[k]) if (evq[k].ch == ch) n++;
        return n;
    endfunction

    function automatic int nth(input int ch, input int idx);
        int n = 0;
        foreach (evq[k]) begin
            if (evq[k].ch == ch) begin
                if (n == idx) return evq[k].e;
                n++;
            end
        end
        return -1;
    endfunction

    initial begin
        int t;
        int r;
        int exp_e[7];
        rst_n        = 1'b0;
        bif.enable_i = 1'b1;
        bif.button_i = 4'b1110;
        tick(3);
        chk("reset_press", int'(bif.press_o), 0);
        chk("reset_level", int'(bif.level_o), 0);

        // pin0 held through reset release
        rst_n = 1'b1;
        tick(20);
        chk("lock_level0", int'(bif.level_o[0]), 1);
        chk("lock_npulse0", npulse(0), 0);
        bif.button_i[0] = 1'b1;
        tick(20);
        chk("lock_rel_level0", int'(bif.level_o[0]), 0);
        bif.button_i[0] = 1'b0;
        t = ecount + 1;
        tick(15);
        bif.button_i[0] = 1'b1;
        tick(15);
        chk("lock_npulse0b", npulse(0), 1);
        chk("lock_edge0", nth(0, 0), t + 11);
        evq.delete();

        // pin2 simple press, 20 clks
        bif.button_i[2] = 1'b0;
        t = ecount + 1;
        goto(t + 10);
        chk("p2_level_pre", int'(bif.level_o[2]), 0);
        goto(t + 11);
        chk("p2_level_on", int'(bif.level_o[2]), 1);
        chk("p2_press_on", int'(bif.press_o[2]), 1);
        goto(t + 12);
        chk("p2_press_off", int'(bif.press_o[2]), 0);
        goto(t + 19);
        bif.button_i[2] = 1'b1;
        r = ecount + 1;
        goto(r + 10);
        chk("p2_level_hold", int'(bif.level_o[2]), 1);
        goto(r + 11);
        chk("p2_level_rel", int'(bif.level_o[2]), 0);
        goto(r + 20);
        chk("p2_npulse", npulse(2), 1);
        chk("p2_edge", nth(2, 0), t + 11);
        evq.delete();

        // pin1 bounce then stable
        bif.button_i[1] = 1'b0; tick(5);
        bif.button_i[1] = 1'b1; tick(3);
        bif.button_i[1] = 1'b0; tick(4);
        bif.button_i[1] = 1'b1; tick(2);
        bif.button_i[1] = 1'b0;
        t = ecount + 1;
        tick(20);
        bif.button_i[1] = 1'b1;
        tick(20);
        chk("bounce_npulse", npulse(1), 1);
        chk("bounce_edge", nth(1, 0), t + 11);
        evq.delete();

        // pin3 press while disabled, then enabled press
        bif.enable_i    = 1'b0;
        bif.button_i[3] = 1'b0;
        tick(15);
        bif.enable_i = 1'b1;
        tick(5);
        bif.button_i[3] = 1'b1;
        tick(20);
        chk("en_lost", npulse(3), 0);
        bif.button_i[3] = 1'b0;
        t = ecount + 1;
        tick(15);
        bif.button_i[3] = 1'b1;
        tick(15);
        chk("en_npulse", npulse(3), 1);
        chk("en_edge", nth(3, 0), t + 11);
        evq.delete();

        // pins 0 and 2 held 100 clks
        bif.button_i[0] = 1'b0;
        bif.button_i[2] = 1'b0;
        t = ecount + 1;
        tick(100);
        bif.button_i[0] = 1'b1;
        bif.button_i[2] = 1'b1;
        tick(20);
        chk("hold_npulse0", npulse(0), 1);
        chk("hold_edge0", nth(0, 0), t + 11);
`ifdef BUTTON_AUTOREPEAT_EN
        exp_e = '{t + 11, t + 51, t + 61, t + 71, t + 81, t + 91, t + 101};
        chk("rep_npulse2", npulse(2), 7);
        for (int k = 0; k < 7; k++)
            chk($sformatf("rep_edge2_%0d", k), nth(2, k), exp_e[k]);
`else
        exp_e = '{t + 11, 0, 0, 0, 0, 0, 0};
        chk("hold_npulse2", npulse(2), 1);
        chk("hold_edge2", nth(2, 0), exp_e[0]);
`endif
        evq.delete();

        // async reset while pulse and level are high
        bif.button_i[2] = 1'b0;
        t = ecount + 1;
        goto(t + 11);
        chk("rst_pre_press", int'(bif.press_o[2]), 1);
        rst_n = 1'b0;
        #1;
        chk("rst_async_press", int'(bif.press_o), 0);
        chk("rst_async_level", int'(bif.level_o), 0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("rst_held_level", int'(bif.level_o[2]), 1);
        bif.button_i[2] = 1'b1;
        tick(30);
        chk("rst_npulse2", npulse(2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
